// File: rtl/ay_pkg.sv
// Shared constants for the AY-3-8912 envelope/mixer output stage.
// Optional feature macro: AY_STEREO_ABC_EN (consumed by the interface and top level).
package ay_pkg;

  // Bit positions inside R13 (env_shape)
  localparam int unsigned ShapeCont = 3;
  localparam int unsigned ShapeAtt  = 2;
  localparam int unsigned ShapeAlt  = 1;
  localparam int unsigned ShapeHold = 0;

  // clken pulses per envelope period tick
  localparam int unsigned PrescaleDefault = 16;

  // Envelope direction encoding
  localparam logic DirDown = 1'b0;
  localparam logic DirUp   = 1'b1;

  // Logarithmic amplitude table, entry [0] is the rightmost element
  localparam logic [15:0][7:0] VolLut = {
    8'd85, 8'd60, 8'd42, 8'd30, 8'd21, 8'd15, 8'd11, 8'd8,
    8'd5,  8'd4,  8'd3,  8'd2,  8'd1,  8'd1,  8'd1,  8'd0
  };

endpackage

// File: rtl/ay_envelope_mixer_if.sv
// Register/generator side bus of the AY envelope/mixer stage.
// AY_STEREO_ABC_EN adds the out_l/out_r stereo outputs.
interface ay_envelope_mixer_if;

  logic        clken;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic        env_shape_wr;
  logic [2:0]  tone;
  logic        noise;
  logic [5:0]  mix_ctl;
  logic [4:0]  vol_a;
  logic [4:0]  vol_b;
  logic [4:0]  vol_c;
  logic [7:0]  out;
`ifdef AY_STEREO_ABC_EN
  logic [7:0]  out_l;
  logic [7:0]  out_r;

  modport master (
    output clken, env_period, env_shape, env_shape_wr, tone, noise, mix_ctl,
    output vol_a, vol_b, vol_c,
    input  out, out_l, out_r
  );

  modport slave (
    input  clken, env_period, env_shape, env_shape_wr, tone, noise, mix_ctl,
    input  vol_a, vol_b, vol_c,
    output out, out_l, out_r
  );
`else
  modport master (
    output clken, env_period, env_shape, env_shape_wr, tone, noise, mix_ctl,
    output vol_a, vol_b, vol_c,
    input  out
  );

  modport slave (
    input  clken, env_period, env_shape, env_shape_wr, tone, noise, mix_ctl,
    input  vol_a, vol_b, vol_c,
    output out
  );
`endif

endinterface

// File: rtl/ay_envelope_gen.sv
// AY hardware envelope: prescaler, period counter and step/direction/hold state.
module ay_envelope_gen
  import ay_pkg::*;
#(
  parameter int unsigned PRESCALE = PrescaleDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clken,
  input  logic [15:0] env_period,
  input  logic [3:0]  env_shape,
  input  logic        env_shape_wr,
  output logic [3:0]  env_level
);

  localparam int unsigned PscW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PscW-1:0] psc_q;
  logic [15:0]     per_q;
  logic [3:0]      step_q;
  logic [3:0]      shape_q;
  logic            dir_q;
  logic            held_q;
  logic            hold_hi_q;

  logic [15:0] eff_period;
  logic        tick;
  logic        step_pulse;

  // A period of 0 behaves like 1
  assign eff_period = (env_period == 16'd0) ? 16'd1 : env_period;
  assign tick       = clken && (psc_q == PscW'(PRESCALE - 1));
  // >= rather than == so a period shrunk mid-count still terminates
  assign step_pulse = tick && (({1'b0, per_q} + 17'd1) >= {1'b0, eff_period});

  // Envelope state; an R13 write restarts everything and wins over a coincident step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psc_q     <= '0;
      per_q     <= '0;
      step_q    <= '0;
      shape_q   <= '0;
      dir_q     <= DirDown;
      held_q    <= 1'b1;
      hold_hi_q <= 1'b0;
    end else if (env_shape_wr) begin
      psc_q     <= '0;
      per_q     <= '0;
      step_q    <= '0;
      shape_q   <= env_shape;
      dir_q     <= env_shape[ShapeAtt] ? DirUp : DirDown;
      held_q    <= 1'b0;
      hold_hi_q <= 1'b0;
    end else begin
      if (clken) psc_q <= tick ? '0 : psc_q + 1'b1;
      if (tick)  per_q <= step_pulse ? '0 : per_q + 16'd1;
      if (step_pulse && !held_q) begin
        if (step_q == 4'hF) begin
          if (!shape_q[ShapeCont]) begin
            held_q    <= 1'b1;
            hold_hi_q <= 1'b0;
          end else if (shape_q[ShapeHold]) begin
            held_q    <= 1'b1;
            hold_hi_q <= shape_q[ShapeAtt] ^ shape_q[ShapeAlt];
          end else begin
            step_q <= '0;
            if (shape_q[ShapeAlt]) dir_q <= ~dir_q;
          end
        end else begin
          step_q <= step_q + 4'd1;
        end
      end
    end
  end

  // Level from step and direction, with the hold override on top
  always_comb begin
    env_level = '0;
    if (held_q)             env_level = hold_hi_q ? 4'hF : 4'h0;
    else if (dir_q == DirUp) env_level = step_q;
    else                    env_level = 4'hF - step_q;
  end

endmodule

// File: rtl/ay_envelope_mixer.sv
// AY-3-8912 output stage: envelope, R7 gating, log amplitude LUT and 3-channel sum.
// Define AY_STEREO_ABC_EN for additional ABC-stereo out_l/out_r outputs.
module ay_envelope_mixer
  import ay_pkg::*;
#(
  parameter int unsigned PRESCALE = PrescaleDefault
) (
  input  logic                clk,
  input  logic                reset,
  ay_envelope_mixer_if.slave  bus
);

  logic [3:0] env_level;
  logic [4:0] vol [3];
  logic [2:0] on;
  logic [3:0] lvl_d [3];
  logic [3:0] lvl_q [3];
  logic [7:0] amp_q [3];
  logic [7:0] out_q;

  ay_envelope_gen #(
    .PRESCALE(PRESCALE)
  ) u_env (
    .clk         (clk),
    .reset       (reset),
    .clken       (bus.clken),
    .env_period  (bus.env_period),
    .env_shape   (bus.env_shape),
    .env_shape_wr(bus.env_shape_wr),
    .env_level   (env_level)
  );

  assign vol[0] = bus.vol_a;
  assign vol[1] = bus.vol_b;
  assign vol[2] = bus.vol_c;

  // Gate each channel by tone/noise (a set disable bit forces that term high)
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      on[i]    = (bus.tone[i] | bus.mix_ctl[i]) & (bus.noise | bus.mix_ctl[i + 3]);
      lvl_d[i] = on[i] ? (vol[i][4] ? env_level : vol[i][3:0]) : 4'h0;
    end
  end

  // S1: gated channel levels
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) lvl_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) lvl_q[i] <= lvl_d[i];
    end
  end

  // S2: logarithmic amplitudes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) amp_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) amp_q[i] <= VolLut[lvl_q[i]];
    end
  end

  // S3: mono sum; table peak 3*85 = 255 so it cannot overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= amp_q[0] + amp_q[1] + amp_q[2];
  end

  assign bus.out = out_q;

`ifdef AY_STEREO_ABC_EN
  logic [8:0] sum_l;
  logic [8:0] sum_r;
  logic [7:0] out_l_q;
  logic [7:0] out_r_q;

  // B is split half into each side; saturation guards against future table changes
  always_comb begin
    sum_l = {1'b0, amp_q[0]} + {2'b00, amp_q[1][7:1]} + 9'd1;
    sum_r = {1'b0, amp_q[2]} + {2'b00, amp_q[1][7:1]} + 9'd1;
  end

  // S3: stereo outputs, saturated to 8 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_l_q <= '0;
      out_r_q <= '0;
    end else begin
      out_l_q <= sum_l[8] ? 8'hFF : sum_l[7:0];
      out_r_q <= sum_r[8] ? 8'hFF : sum_r[7:0];
    end
  end

  assign bus.out_l = out_l_q;
  assign bus.out_r = out_r_q;
`endif

endmodule

// File: tb/tb_ay_envelope_mixer.sv
// Directed self-checking bench for ay_envelope_mixer (PRESCALE = 16).
module tb_ay_envelope_mixer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   lut [16] = '{0, 1, 1, 1, 2, 3, 4, 5, 8, 11, 15, 21, 30, 42, 60, 85};

  ay_envelope_mixer_if bus ();

  ay_envelope_mixer #(
    .PRESCALE(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse R13 and land in the middle of the window showing envelope step 0.
  task automatic start_env(input logic [3:0] shape, input logic [15:0] period);
    bus.env_period   = period;
    bus.env_shape    = shape;
    bus.env_shape_wr = 1'b1;
    wait_neg(1);
    bus.env_shape_wr = 1'b0;
    wait_neg(10);
  endtask

  task automatic env_only_setup();
    bus.clken   = 1'b1;
    bus.mix_ctl = 6'h3F;
    bus.vol_a   = 5'h10;
    bus.vol_b   = 5'h00;
    bus.vol_c   = 5'h00;
  endtask

  task automatic test_reset();
    bus.clken = 1'b0; bus.env_period = 16'd1; bus.env_shape = 4'h0; bus.env_shape_wr = 1'b0;
    bus.tone = 3'b000; bus.noise = 1'b0; bus.mix_ctl = 6'h3F;
    bus.vol_a = 5'h0F; bus.vol_b = 5'h00; bus.vol_c = 5'h00;
    reset = 1'b1;
    wait_neg(4);
    checks++;
    if (bus.out !== 8'd0) begin
      errors++; $display("FAIL reset_out got=%0d want=0", bus.out);
    end
    reset = 1'b0;
    wait_neg(2);
    checks++;
    if (bus.out !== 8'd0) begin
      errors++; $display("FAIL latency_early got=%0d want=0", bus.out);
    end
    wait_neg(1);
    checks++;
    if (bus.out !== 8'd85) begin
      errors++; $display("FAIL latency_3 got=%0d want=85", bus.out);
    end
  endtask

  task automatic test_fixed_mix();
    bus.vol_a = 5'h0F; bus.vol_b = 5'h0F; bus.vol_c = 5'h0F; bus.mix_ctl = 6'h3F;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'd255) begin
      errors++; $display("FAIL fixed_all15 got=%0d want=255", bus.out);
    end
    bus.vol_a = 5'h08; bus.vol_b = 5'h0C; bus.vol_c = 5'h04;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'd40) begin
      errors++; $display("FAIL fixed_8_12_4 got=%0d want=40", bus.out);
    end
  endtask

  task automatic test_tone_toggle();
    logic tv [16];
    int   exp_v;
    bus.vol_a = 5'h0F; bus.vol_b = 5'h0F; bus.vol_c = 5'h0F;
    bus.mix_ctl = 6'h3E;
    bus.tone = 3'b111;
    wait_neg(4);
    for (int i = 0; i < 16; i++) begin
      if (i >= 3) begin
        exp_v = tv[i - 3] ? 255 : 170;
        checks++;
        if (bus.out !== 8'(exp_v)) begin
          errors++; $display("FAIL tone_toggle[%0d] got=%0d want=%0d", i, bus.out, exp_v);
        end
      end
      tv[i] = i[0];
      bus.tone[0] = tv[i];
      wait_neg(1);
    end
  endtask

  task automatic test_noise_gate();
    bus.vol_a = 5'h0F; bus.vol_b = 5'h00; bus.vol_c = 5'h00;
    bus.mix_ctl = 6'h07; bus.tone = 3'b000; bus.noise = 1'b0;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'd0) begin
      errors++; $display("FAIL noise_low got=%0d want=0", bus.out);
    end
    bus.noise = 1'b1;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'd85) begin
      errors++; $display("FAIL noise_high got=%0d want=85", bus.out);
    end
    bus.mix_ctl = 6'h38; bus.noise = 1'b0; bus.tone = 3'b001;
    bus.vol_b = 5'h0F; bus.vol_c = 5'h0F;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'd85) begin
      errors++; $display("FAIL tone_only_a got=%0d want=85", bus.out);
    end
  endtask

  task automatic test_env_attack_hold(input logic [15:0] period);
    int exp_v;
    env_only_setup();
    start_env(4'hD, period);
    for (int k = 0; k < 18; k++) begin
      exp_v = (k < 16) ? lut[k] : 85;
      checks++;
      if (bus.out !== 8'(exp_v)) begin
        errors++; $display("FAIL attack_hold p=%0d k=%0d got=%0d want=%0d", period, k, bus.out,
                           exp_v);
      end
      wait_neg(16);
    end
  endtask

  task automatic test_env_triangle();
    int exp_v;
    env_only_setup();
    start_env(4'hA, 16'd1);
    for (int k = 0; k < 36; k++) begin
      if (k < 16)      exp_v = lut[15 - k];
      else if (k < 32) exp_v = lut[k - 16];
      else             exp_v = lut[15 - (k - 32)];
      checks++;
      if (bus.out !== 8'(exp_v)) begin
        errors++; $display("FAIL triangle k=%0d got=%0d want=%0d", k, bus.out, exp_v);
      end
      wait_neg(16);
    end
  endtask

  task automatic test_env_decay_restart();
    int exp_v;
    env_only_setup();
    start_env(4'h0, 16'd1);
    for (int k = 0; k < 18; k++) begin
      exp_v = (k < 16) ? lut[15 - k] : 0;
      checks++;
      if (bus.out !== 8'(exp_v)) begin
        errors++; $display("FAIL decay k=%0d got=%0d want=%0d", k, bus.out, exp_v);
      end
      wait_neg(16);
    end
    start_env(4'h0, 16'd1);
    wait_neg(16 * 7);
    checks++;
    if (bus.out !== 8'd8) begin
      errors++; $display("FAIL decay_step7 got=%0d want=8", bus.out);
    end
    bus.env_shape_wr = 1'b1;
    wait_neg(1);
    bus.env_shape_wr = 1'b0;
    wait_neg(2);
    checks++;
    if (bus.out !== 8'd8) begin
      errors++; $display("FAIL restart_before got=%0d want=8", bus.out);
    end
    wait_neg(1);
    checks++;
    if (bus.out !== 8'd85) begin
      errors++; $display("FAIL restart_at15 got=%0d want=85", bus.out);
    end
  endtask

  task automatic test_period_two();
    env_only_setup();
    bus.env_period   = 16'd2;
    bus.env_shape    = 4'hD;
    bus.env_shape_wr = 1'b1;
    wait_neg(1);
    bus.env_shape_wr = 1'b0;
    wait_neg(18);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.out !== 8'(lut[k])) begin
        errors++; $display("FAIL period2 k=%0d got=%0d want=%0d", k, bus.out, lut[k]);
      end
      wait_neg(32);
    end
  endtask

  task automatic test_clken_freeze();
    logic [7:0] frozen;
    env_only_setup();
    start_env(4'hD, 16'd1);
    wait_neg(16 * 9);
    bus.clken = 1'b0;
    wait_neg(4);
    frozen = 8'(lut[9]);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out !== frozen) begin
        errors++; $display("FAIL clken_freeze[%0d] got=%0d want=%0d", i, bus.out, frozen);
      end
      wait_neg(16);
    end
    bus.vol_b = 5'h0F;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'(lut[9] + 85)) begin
      errors++; $display("FAIL clken_track got=%0d want=%0d", bus.out, lut[9] + 85);
    end
    bus.vol_b = 5'h00;
    bus.clken = 1'b1;
    wait_neg(3);
  endtask

  task automatic test_reset_midramp();
    env_only_setup();
    start_env(4'hD, 16'd1);
    wait_neg(16 * 12);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out !== 8'd0) begin
      errors++; $display("FAIL async_reset got=%0d want=0", bus.out);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_neg(40);
    checks++;
    if (bus.out !== 8'd0) begin
      errors++; $display("FAIL held_after_reset got=%0d want=0", bus.out);
    end
    bus.vol_b = 5'h0F;
    wait_neg(3);
    checks++;
    if (bus.out !== 8'd85) begin
      errors++; $display("FAIL held_plus_fixed got=%0d want=85", bus.out);
    end
    bus.vol_b = 5'h00;
    start_env(4'hD, 16'd1);
    wait_neg(16 * 8);
    checks++;
    if (bus.out !== 8'(lut[8])) begin
      errors++; $display("FAIL rearm_after_reset got=%0d want=%0d", bus.out, lut[8]);
    end
  endtask

`ifdef AY_STEREO_ABC_EN
  task automatic test_stereo();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_l !== 8'd0 || bus.out_r !== 8'd0) begin
      errors++; $display("FAIL stereo_reset got=%0d/%0d want=0/0", bus.out_l, bus.out_r);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.mix_ctl = 6'h3F; bus.vol_a = 5'h0F; bus.vol_b = 5'h0F; bus.vol_c = 5'h00;
    wait_neg(3);
    checks++;
    if (bus.out_l !== 8'd128 || bus.out_r !== 8'd43) begin
      errors++; $display("FAIL stereo_abc got=%0d/%0d want=128/43", bus.out_l, bus.out_r);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_mix();
    test_tone_toggle();
    test_noise_gate();
    test_env_attack_hold(16'd1);
    test_env_attack_hold(16'd0);
    test_env_triangle();
    test_env_decay_restart();
    test_period_two();
    test_clken_freeze();
    test_reset_midramp();
`ifdef AY_STEREO_ABC_EN
    test_stereo();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
